// File: rtl/col_input_ctrl.sv
// col_input_ctrl: buffers ROWS operand words, then injects them into one PE column
// with a one-row-per-cycle skew and a one-hot per-row valid strobe.
module col_input_ctrl #(
    parameter int ROWS = 8,
    parameter int INWIDTH = 32,
    localparam int CW = $clog2(ROWS)
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [INWIDTH-1:0] in_w,
    input  logic               wvalid,
    output logic               wready,
    input  logic               en,
    output logic [INWIDTH-1:0] out_w [0:ROWS-1],
    output logic [ROWS-1:0]    out_v,
    output logic               busy
);
    typedef enum logic {FILL, ISSUE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     wcnt_q, wcnt_d, icnt_q, icnt_d;
    logic [INWIDTH-1:0] buf_q [0:ROWS-1];
    logic [ROWS-1:0]   out_v_d;
    logic              wr_en, iss_en, last_w, last_i;

    assign wready = (state_q == FILL);
    assign busy   = (state_q == ISSUE);
    assign last_w = (wcnt_q == CW'(ROWS - 1));
    assign last_i = (icnt_q == CW'(ROWS - 1));

    // The FSM transition replaces counter wrap, so non-power-of-2 ROWS never overrun.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        icnt_d  = icnt_q;
        out_v_d = '0;
        wr_en   = 1'b0;
        iss_en  = 1'b0;
        if (state_q == FILL) begin
            wr_en  = wvalid;
            icnt_d = '0;
            if (wvalid) begin
                wcnt_d  = last_w ? '0 : wcnt_q + 1'b1;
                state_d = last_w ? ISSUE : FILL;
            end
        end else if (en) begin
            iss_en  = 1'b1;
            out_v_d = ROWS'(1) << icnt_q;
            icnt_d  = last_i ? '0 : icnt_q + 1'b1;
            state_d = last_i ? FILL : ISSUE;
            wcnt_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= FILL;
            wcnt_q  <= '0;
            icnt_q  <= '0;
            out_v   <= '0;
            for (int i = 0; i < ROWS; i++) begin
                buf_q[i] <= '0;
                out_w[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            icnt_q  <= icnt_d;
            out_v   <= out_v_d;
            if (wr_en) buf_q[wcnt_q] <= in_w;
            if (iss_en) out_w[icnt_q] <= buf_q[icnt_q];
        end
    end
endmodule

// File: tb/tb_col_input_ctrl.sv
// tb_col_input_ctrl: directed checks of col_input_ctrl at ROWS=8/INWIDTH=32 and ROWS=5/INWIDTH=16.
module tb_col_input_ctrl;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] in_w8 = '0;
    logic        wvalid8 = 1'b0, en8 = 1'b1, wready8, busy8;
    logic [31:0] out_w8 [0:7];
    logic [7:0]  out_v8;

    logic [15:0] in_w5 = '0;
    logic        wvalid5 = 1'b0, en5 = 1'b1, wready5, busy5;
    logic [15:0] out_w5 [0:4];
    logic [4:0]  out_v5;

    col_input_ctrl #(.ROWS(8), .INWIDTH(32)) dut8 (
        .clk(clk), .rstn(rstn), .in_w(in_w8), .wvalid(wvalid8), .wready(wready8),
        .en(en8), .out_w(out_w8), .out_v(out_v8), .busy(busy8));

    col_input_ctrl #(.ROWS(5), .INWIDTH(16)) dut5 (
        .clk(clk), .rstn(rstn), .in_w(in_w5), .wvalid(wvalid5), .wready(wready5),
        .en(en5), .out_w(out_w5), .out_v(out_v5), .busy(busy5));

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        wv;
        logic [31:0] d;
        logic        en;
        logic        exp_wr;
        logic        exp_busy;
        logic [7:0]  exp_v;
        int          widx;
        logic [31:0] exp_w;
    } vec_t;

    vec_t tbl [17];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents words base..base+n-1, advancing only on accepted handshakes.
    task automatic write_words(input int base, input int n, input bit gap, input bit keep);
        int cnt = 0;
        int t = 0;
        bit acc;
        while (cnt < n && t < 100) begin
            wvalid8 = gap ? (t % 2 == 0) : 1'b1;
            in_w8   = 32'(base + cnt);
            acc     = wvalid8 && wready8;
            step();
            t++;
            if (acc) cnt++;
            if (cnt < n) begin
                chk("fill_busy", busy8, 1'b0);
                chk("fill_wready", wready8, 1'b1);
            end
        end
        chk("fill_count", cnt, n);
        chk("fill_done_busy", busy8, 1'b1);
        chk("fill_done_wready", wready8, 1'b0);
        chk("fill_done_outv", out_v8, 8'h00);
        if (keep) in_w8 = 32'(base + n);
        else wvalid8 = 1'b0;
    endtask

    task automatic issue_check(input int base, input int stall_row, input int stall_len);
        for (int i = 0; i < 8; i++) begin
            en8 = 1'b1;
            step();
            chk("iss_outv", out_v8, 32'(1) << i);
            chk("iss_outw", out_w8[i], 32'(base + i));
            chk("iss_busy", busy8, i != 7);
            chk("iss_wready", wready8, i == 7);
            if (i == stall_row) begin
                for (int s = 0; s < stall_len; s++) begin
                    en8 = 1'b0;
                    step();
                    chk("stall_outv", out_v8, 8'h00);
                    chk("stall_busy", busy8, 1'b1);
                    chk("stall_hold_w", out_w8[i], 32'(base + i));
                end
            end
        end
        en8 = 1'b1;
    endtask

    initial begin
        for (int k = 0; k < 8; k++)
            tbl[k] = '{1'b1, 32'(k + 1), 1'b1, k != 7, k == 7, 8'h00, 0, 32'h0};
        for (int i = 0; i < 8; i++)
            tbl[8 + i] = '{1'b0, 32'h0, 1'b1, i == 7, i != 7, 8'(1 << i), i, 32'(i + 1)};
        tbl[16] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 8'h00, 7, 32'h8};

        #22;
        chk("rst_wready", wready8, 1'b1);
        chk("rst_busy", busy8, 1'b0);
        chk("rst_outv", out_v8, 8'h00);
        chk("rst_outw", out_w8[0], 32'h0);
        rstn = 1'b1;
        #2;

        for (int k = 0; k < 17; k++) begin
            wvalid8 = tbl[k].wv;
            in_w8   = tbl[k].d;
            en8     = tbl[k].en;
            step();
            chk("tbl_wready", wready8, tbl[k].exp_wr);
            chk("tbl_busy", busy8, tbl[k].exp_busy);
            chk("tbl_outv", out_v8, tbl[k].exp_v);
            chk("tbl_outw", out_w8[tbl[k].widx], tbl[k].exp_w);
        end

        write_words(32'hA0, 8, 1'b0, 1'b1);
        issue_check(32'hA0, -1, 0);
        write_words(32'hA8, 8, 1'b0, 1'b0);
        issue_check(32'hA8, -1, 0);

        write_words(1, 8, 1'b0, 1'b0);
        issue_check(1, 2, 3);

        write_words(32'h30, 8, 1'b1, 1'b0);
        issue_check(32'h30, -1, 0);

        write_words(32'h40, 8, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("pre_rst_outv", out_v8, 32'(1) << i);
        end
        #2;
        rstn = 1'b0;
        #1;
        chk("mid_rst_outv", out_v8, 8'h00);
        chk("mid_rst_outw4", out_w8[4], 32'h0);
        chk("mid_rst_outw0", out_w8[0], 32'h0);
        chk("mid_rst_wready", wready8, 1'b1);
        chk("mid_rst_busy", busy8, 1'b0);
        #1;
        rstn = 1'b1;
        write_words(32'h50, 8, 1'b0, 1'b0);
        issue_check(32'h50, -1, 0);

        for (int r = 0; r < 2; r++) begin
            for (int j = 0; j < 5; j++) begin
                wvalid5 = 1'b1;
                in_w5   = 16'(16'h100 * (r + 1) + j);
                chk("r5_wready", wready5, 1'b1);
                step();
            end
            wvalid5 = 1'b0;
            chk("r5_busy", busy5, 1'b1);
            chk("r5_wready_lo", wready5, 1'b0);
            for (int i = 0; i < 5; i++) begin
                step();
                chk("r5_outv", out_v5, 32'(1) << i);
                chk("r5_outw", out_w5[i], 32'(16'h100 * (r + 1) + i));
                chk("r5_wready_iss", wready5, i == 4);
            end
            step();
            chk("r5_idle_outv", out_v5, 5'h00);
            chk("r5_idle_busy", busy5, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
